// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run / step / breakpoint sequencer for the single-cycle core.
//
// Instead of gating or dividing the CPU clock, this block produces a
// one-cycle PC-update enable (pc_en) in the clk domain. The core loads NPC
// into its PC only on cycles where pc_en is high.
//
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   run_i        - switch, 1 = run continuously
//   slow_i       - switch, 1 = slow tick rate (2^DIV_SLOW), else 2^DIV_FAST
//   btn_step     - raw asynchronous step pushbutton
//   bp_en        - breakpoint enable
//   bp_addr      - breakpoint PC (byte address)
//   pc           - current PC from the core
//   clr_cnt      - synchronous clear of instr_count
//   pc_en        - one-cycle strobe: core advances PC on this edge
//   state_o      - 00 HALT, 01 RUN, 10 STEP, 11 BRK
//   halted       - state is HALT or BRK
//   brk_hit      - state is BRK
//   instr_count  - number of pc_en strobes since reset or clear
module cpu_run_ctrl #(
  parameter int DIV_FAST = 25,
  parameter int DIV_SLOW = 27,
  parameter int DB_CNT   = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  input  logic        slow_i,
  input  logic        btn_step,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic        clr_cnt,
  output logic        pc_en,
  output logic [1:0]  state_o,
  output logic        halted,
  output logic        brk_hit,
  output logic [31:0] instr_count
);

  localparam int DB_W = $clog2(DB_CNT + 1);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_BRK  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_SLOW-1:0] div_q, div_d;
  logic [1:0]          sync_q, sync_d;
  logic                db_level_q, db_level_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                step_pend_q, step_pend_d;
  logic                skip_bp_q, skip_bp_d;
  logic                halted_q, halted_d;
  logic                brk_hit_q, brk_hit_d;
  logic [31:0]         count_q, count_d;

  logic tick;
  logic bp_hit;
  logic db_rise;
  logic pc_en_fsm;

  // Tick generator. The counter is never reset by slow_i, so switching
  // rate only changes which bits must be all-ones.
  assign div_d = div_q + DIV_SLOW'(1);
  assign tick  = slow_i ? (&div_q) : (&div_q[DIV_FAST-1:0]);

  // The breakpoint is suppressed for the first instruction after leaving
  // HALT so that resuming while parked on bp_addr makes progress.
  assign bp_hit = bp_en & (pc == bp_addr) & ~skip_bp_q;

  // Synchroniser (sync_q[1] is the clean sample) and debouncer. The level
  // flips on the DB_CNT-th consecutive differing sample; any agreeing
  // sample restarts the count.
  always_comb begin
    sync_d     = {sync_q[0], btn_step};
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    db_rise    = 1'b0;
    if (sync_q[1] != db_level_q) begin
      if (db_cnt_q == DB_W'(DB_CNT - 1)) begin
        db_level_d = ~db_level_q;
        db_rise    = ~db_level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Sequencer next-state and strobe.
  always_comb begin
    state_d     = state_q;
    pc_en_fsm   = 1'b0;
    skip_bp_d   = skip_bp_q;
    step_pend_d = step_pend_q | db_rise;
    case (state_q)
      S_HALT: begin
        if (run_i) begin
          // Run wins over a pending step; the pending step is discarded.
          state_d     = S_RUN;
          skip_bp_d   = 1'b1;
          step_pend_d = 1'b0;
        end else if (step_pend_q) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        step_pend_d = 1'b0;
        if (!run_i) begin
          state_d = S_HALT;
        end else if (tick && bp_hit) begin
          // Stop before executing the instruction at bp_addr.
          state_d = S_BRK;
        end else if (tick) begin
          pc_en_fsm = 1'b1;
          skip_bp_d = 1'b0;
        end
      end
      S_STEP: begin
        // run_i and the breakpoint are ignored until the step retires.
        if (tick) begin
          pc_en_fsm   = 1'b1;
          step_pend_d = 1'b0;
          skip_bp_d   = 1'b0;
          state_d     = S_HALT;
        end
      end
      S_BRK: begin
        if (!run_i) begin
          state_d = S_HALT;
        end else if (step_pend_q) begin
          state_d = S_STEP;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // No strobe while reset is asserted.
  assign pc_en = pc_en_fsm & ~rst;

  always_comb begin
    halted_d  = (state_d == S_HALT) || (state_d == S_BRK);
    brk_hit_d = (state_d == S_BRK);
    // Clear has priority over a coincident increment.
    count_d   = clr_cnt ? 32'd0 : (count_q + 32'(pc_en));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HALT;
      div_q       <= '0;
      sync_q      <= '0;
      db_level_q  <= 1'b0;
      db_cnt_q    <= '0;
      step_pend_q <= 1'b0;
      skip_bp_q   <= 1'b0;
      halted_q    <= 1'b1;
      brk_hit_q   <= 1'b0;
      count_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sync_q      <= sync_d;
      db_level_q  <= db_level_d;
      db_cnt_q    <= db_cnt_d;
      step_pend_q <= step_pend_d;
      skip_bp_q   <= skip_bp_d;
      halted_q    <= halted_d;
      brk_hit_q   <= brk_hit_d;
      count_q     <= count_d;
    end
  end

  assign state_o     = state_q;
  assign halted      = halted_q;
  assign brk_hit     = brk_hit_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with small dividers and debounce.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_i, slow_i, btn_step, bp_en, clr_cnt;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        pc_en, halted, brk_hit;
  logic [1:0]  state_o;
  logic [31:0] instr_count;

  logic        pc_set;
  logic [31:0] pc_set_val;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DIV_FAST(2), .DIV_SLOW(3), .DB_CNT(4)) dut (
    .clk(clk), .rst(rst), .run_i(run_i), .slow_i(slow_i),
    .btn_step(btn_step), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .clr_cnt(clr_cnt), .pc_en(pc_en), .state_o(state_o), .halted(halted),
    .brk_hit(brk_hit), .instr_count(instr_count)
  );

  // Core PC model: +4 per strobe, optional bench load.
  always @(posedge clk) begin
    if (rst) pc <= 32'd0;
    else if (pc_set) pc <= pc_set_val;
    else if (pc_en) pc <= pc + 32'd4;
  end

  always @(posedge clk) begin
    if (pc_en) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Waits up to 'bound' falling edges for a strobe; an expired bound fails.
  task automatic wait_pc_en(input int bound, input string name, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (pc_en) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: no pc_en within %0d cycles", name, bound);
    end else begin
      $display("ok   %s: pc_en seen", name);
    end
  endtask

  typedef struct {
    logic        run;
    logic        slow;
    logic        exp_pc_en;
    logic [1:0]  exp_state;
    logic [31:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 36;
  vec_t vecs[NVEC];

  initial begin
    int  base;
    int  tally;
    bit  found;
    bit  seen_step;
    logic [31:0] pc_hold;

    // Table for the run phase, one row per cycle from 20 cycles after reset.
    // Divider is 0 when reset is released, so fast ticks fall on cycles
    // n%4==3; slow mode (from cycle 40) ticks on n%8==7.
    tally = 0;
    for (int i = 0; i < NVEC; i++) begin
      int n;
      n = 20 + i;
      vecs[i].run       = 1'b1;
      vecs[i].slow      = (n >= 40);
      vecs[i].exp_pc_en = (n >= 23 && n < 40 && (n % 4) == 3) ||
                          (n >= 40 && (n % 8) == 7);
      vecs[i].exp_state = (n == 20) ? 2'b00 : 2'b01;
      vecs[i].exp_cnt   = tally;
      if (vecs[i].exp_pc_en) tally++;
    end

    rst = 1'b1; run_i = 0; slow_i = 0; btn_step = 0; bp_en = 0;
    clr_cnt = 0; bp_addr = 32'd0; pc_set = 0; pc_set_val = 32'd0;

    repeat (3) @(negedge clk);
    chk("reset state_o", 32'(state_o), 32'd0);
    chk("reset halted", 32'(halted), 32'd1);
    chk("reset brk_hit", 32'(brk_hit), 32'd0);
    chk("reset pc_en", 32'(pc_en), 32'd0);
    chk("reset instr_count", instr_count, 32'd0);
    rst = 1'b0;

    base = pulse_cnt;
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("idle no pc_en", 32'(pulse_cnt - base), 32'd0);
    chk("idle state_o", 32'(state_o), 32'd0);

    // Continuous run, fast then slow.
    for (int i = 0; i < NVEC; i++) begin
      run_i  = vecs[i].run;
      slow_i = vecs[i].slow;
      #1;
      chk($sformatf("vec%0d pc_en", i), 32'(pc_en), 32'(vecs[i].exp_pc_en));
      chk($sformatf("vec%0d state_o", i), 32'(state_o), 32'(vecs[i].exp_state));
      chk($sformatf("vec%0d instr_count", i), instr_count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d pc", i), pc, vecs[i].exp_cnt * 4);
      @(negedge clk);
    end

    // Reset mid-RUN.
    rst = 1'b1;
    #1;
    chk("rst cycle pc_en", 32'(pc_en), 32'd0);
    @(negedge clk);
    chk("rst midrun state_o", 32'(state_o), 32'd0);
    chk("rst midrun instr_count", instr_count, 32'd0);
    chk("rst midrun halted", 32'(halted), 32'd1);

    // Breakpoint at 0x0C while running from 0.
    rst = 1'b0; slow_i = 1'b0; run_i = 1'b1; bp_en = 1'b1; bp_addr = 32'h0C;
    base = pulse_cnt;
    repeat (16) @(negedge clk);
    chk("bp pulses before brk", 32'(pulse_cnt - base), 32'd3);
    chk("bp state_o", 32'(state_o), 32'd3);
    chk("bp brk_hit", 32'(brk_hit), 32'd1);
    chk("bp halted", 32'(halted), 32'd1);
    base = pulse_cnt;
    repeat (50) @(negedge clk);
    chk("brk holds no pc_en", 32'(pulse_cnt - base), 32'd0);
    chk("brk holds pc", pc, 32'h0C);
    chk("brk holds state_o", 32'(state_o), 32'd3);

    // Step out of BRK with a 10-cycle press; drop run_i while in STEP.
    base = pulse_cnt;
    seen_step = 1'b0;
    btn_step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (state_o == 2'b10 && !seen_step) begin
        seen_step = 1'b1;
        run_i = 1'b0;
      end
    end
    btn_step = 1'b0;
    repeat (20) @(negedge clk);
    chk("step went through STEP", 32'(seen_step), 32'd1);
    chk("step pulses", 32'(pulse_cnt - base), 32'd1);
    chk("step pc", pc, 32'h10);
    chk("step state_o", 32'(state_o), 32'd0);
    run_i = 1'b0;

    // Three-cycle glitch is one sample short of acceptance.
    base = pulse_cnt;
    btn_step = 1'b1;
    repeat (3) @(negedge clk);
    btn_step = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch pulses", 32'(pulse_cnt - base), 32'd0);
    chk("glitch state_o", 32'(state_o), 32'd0);

    // Drop run_i on a tick cycle.
    run_i = 1'b1;
    wait_pc_en(20, "run restart", found);
    repeat (4) @(negedge clk);
    pc_hold = pc;
    run_i = 1'b0;
    #1;
    chk("run drop on tick pc_en", 32'(pc_en), 32'd0);
    @(negedge clk);
    chk("run drop state_o", 32'(state_o), 32'd0);
    chk("run drop pc", pc, pc_hold);

    // Resume while parked on the breakpoint address.
    pc_set = 1'b1; pc_set_val = 32'h0C;
    @(negedge clk);
    pc_set = 1'b0;
    chk("park pc", pc, 32'h0C);
    run_i = 1'b1;
    wait_pc_en(20, "skip first tick", found);
    chk("skip pc at strobe", pc, 32'h0C);
    @(negedge clk);
    chk("skip state_o", 32'(state_o), 32'd1);
    chk("skip pc after", pc, 32'h10);
    run_i = 1'b0;
    @(negedge clk);
    chk("skip halt state_o", 32'(state_o), 32'd0);

    // Counter wrap from a preloaded all-ones value.
    force dut.count_d = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.count_d;
    @(negedge clk);
    chk("preload instr_count", instr_count, 32'hFFFF_FFFF);
    run_i = 1'b1;
    wait_pc_en(20, "wrap strobe", found);
    @(negedge clk);
    chk("wrap instr_count", instr_count, 32'd0);
    wait_pc_en(20, "count strobe", found);
    @(negedge clk);
    chk("count after wrap", instr_count, 32'd1);
    wait_pc_en(20, "clr strobe", found);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk("clr beats increment", instr_count, 32'd0);
    run_i = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step/breakpoint sequencer for the single-cycle RISC-V core.
- Replaces the free-running divided CPU clock with a one-cycle PC-update enable, `pc_en`, in the `clk` domain. The core's PC register loads NPC only when `pc_en`=1.
- Provides continuous run, a debounced single-step button, one PC breakpoint, and a retired-instruction counter for the board display.

Parameters:
- DIV_FAST, 25, tick period exponent in fast mode (tick every 2^DIV_FAST clk cycles)
- DIV_SLOW, 27, tick period exponent in slow mode
- DB_CNT, 1000000, consecutive stable samples required to accept a button level

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- run_i  input  1  switch: 1 = run continuously
- slow_i  input  1  switch: 1 = select DIV_SLOW tick rate
- btn_step  input  1  raw asynchronous step pushbutton
- bp_en  input  1  breakpoint enable
- bp_addr  input  32  breakpoint PC (byte address)
- pc  input  32  current PC from the core
- clr_cnt  input  1  synchronous clear of `instr_count`
- pc_en  output  1  one-cycle strobe; the core advances PC to NPC this clk edge
- state_o  output  2  00 HALT, 01 RUN, 10 STEP, 11 BRK
- halted  output  1  1 when state is HALT or BRK
- brk_hit  output  1  1 when state is BRK
- instr_count  output  32  number of `pc_en` strobes since reset or clear

Behaviour:
- One clock is used: `clk`. Reset is synchronous and active-high on `rst`. The `rst` port name matches the core's register file.
- Reset values: state=HALT, `pc_en`=0, `halted`=1, `brk_hit`=0, `instr_count`=0, divider=0, synchroniser and debouncer cleared (debounced level 0), `step_pend`=0, `skip_bp`=0.
- Tick generator:
  - Free-running counter of width DIV_SLOW.
  - `tick`=1 for one cycle when the low DIV_FAST bits (fast mode) or all DIV_SLOW bits (slow mode) are all-ones.
  - Changing `slow_i` does not reset the counter.
- Step button:
  - Two-flop synchroniser, then a debounce counter.
  - The debounced level changes only after the synchronised input differs from it for DB_CNT consecutive cycles. Any reversion restarts the count.
  - A 0→1 edge of the debounced level sets `step_pend`.
  - `step_pend` is cleared when consumed, and on any cycle in RUN (steps are ignored while running).
- Breakpoint match: `bp_hit` = `bp_en` & (`pc` == `bp_addr`) & ~`skip_bp`.
- FSM (evaluated every clk; `pc_en` is combinational from state, `tick` and inputs; at most one `pc_en` per tick):
  - HALT:
    - `run_i`=1 → RUN; set `skip_bp`; clear `step_pend`. Run has priority over a pending step.
    - else `step_pend` → STEP.
  - RUN, in priority order:
    - `run_i`=0 → HALT; no `pc_en` this cycle, even if `tick`=1.
    - else if `tick` & `bp_hit` → BRK; no `pc_en`. The instruction at `bp_addr` is not executed.
    - else if `tick`: `pc_en`=1; clear `skip_bp`.
  - STEP:
    - Wait for `tick`.
    - On `tick`: `pc_en`=1, clear `step_pend` and `skip_bp`, → HALT.
    - The breakpoint is ignored in STEP.
    - `run_i` is ignored until the return to HALT.
  - BRK:
    - `run_i`=0 → HALT.
    - else `step_pend` → STEP, which single-steps past the breakpoint.
    - Remaining in BRK with `run_i` held at 1 does not resume.
- `skip_bp` lets RUN, entered from HALT while `pc` == `bp_addr`, execute that instruction once without re-triggering.
- `instr_count`:
  - +1 on every `pc_en`; wraps 0xFFFFFFFF→0.
  - `clr_cnt`=1 forces 0 that cycle and has priority over a simultaneous increment.
- Reset mid-operation (any state, including mid-debounce or mid-step) returns all state to reset values on the next edge. No `pc_en` is issued on the reset cycle.

Test Plan:
- Bench parameters: DIV_FAST=2, DIV_SLOW=3, DB_CNT=4. The bench PC model does `pc` += 4 on `pc_en`, starting at 0.
- Reset held 3 cycles → `state_o`=00, `halted`=1, `pc_en`=0, `instr_count`=0; no `pc_en` over 20 further cycles with all inputs 0.
- `run_i`=1, `slow_i`=0 → `pc_en` pulses exactly every 4 cycles; after 5 pulses `instr_count`=5 and `pc`=0x14. Switch to `slow_i`=1 → `pc_en` spacing becomes 8 cycles.
- `bp_en`=1, `bp_addr`=0x0C, `run_i`=1 from `pc`=0 → exactly 3 `pc_en` pulses, then `state_o`=11, `brk_hit`=1, `pc` stays 0x0C for 50 cycles.
- From BRK, hold `btn_step` high for 10 cycles → exactly one `pc_en`, `pc`=0x10, `state_o`=00. A 3-cycle glitch on `btn_step` → no `pc_en`, `state_o` unchanged.
- In RUN, drop `run_i` on a tick cycle → no `pc_en` that cycle, `state_o`=00. Resume with `pc`=`bp_addr` → first tick gives `pc_en` (skip works) and no BRK. Assert `rst` mid-RUN → next cycle `state_o`=00, `instr_count`=0.
- Preload via 0xFFFFFFFF pulses (bench force) → next `pc_en` gives `instr_count`=0. `clr_cnt` coinciding with `pc_en` → `instr_count`=0.
